// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD conversion engines (binary-to-BCD and
// BCD-to-binary). Holds the converter state type and the per-digit constants
// used by the shift-and-correct algorithms.
// ----------------------------------------------------------------------------
package bcd_pkg;

  // Converter FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_e;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Reverse double-dabble correction: after a right shift, a digit holding
  // 8 or more received a carried-in 1 worth "5" (half of ten), which must be
  // expressed as 5 instead of 8 -> subtract 3.
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_VALUE  = 4'd3;

  // Largest legal decimal digit.
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT  = 4'd9;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// ----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational per-digit correction for reverse double-dabble: a nibble that
// is >= 8 after the right shift has 3 subtracted, otherwise it passes through.
//
// Ports:
//   digit_in   in   BCD_DIGIT_W  shifted digit
//   digit_out  out  BCD_DIGIT_W  corrected digit
// ----------------------------------------------------------------------------
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in - BCD_ADJ_VALUE)
                                                  : digit_in;

endmodule : bcd_digit_adjust

// File: rtl/bcd_to_binary.sv
// ----------------------------------------------------------------------------
// bcd_to_binary
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// Each SHIFT cycle shifts {S,R} right one bit and then corrects every BCD
// digit of S that is >= 8 by subtracting 3. After OUTPUT_WIDTH iterations R
// holds the binary value.
//
// Optional feature macro: BCD2BIN_VALIDATE_EN
//   defined   : nibbles > 9 are rejected at start (o_bad_digit), and a
//               non-zero residue in S at completion raises o_overflow.
//   undefined : o_bad_digit / o_overflow stay 0, every start runs the full
//               shift sequence.
//
// Handshake: i_start is a request honoured only while idle (o_busy low);
// there is no back-pressure and a start while busy is dropped. Completion is
// signalled by o_dv, a single-cycle strobe with no ready; o_bad_digit and
// o_overflow are meaningful only in that cycle, o_binary holds until the next
// successful completion.
//
// Ports:
//   clk          in   1                 system clock (rising edge)
//   rst_n        in   1                 asynchronous active-low reset
//   i_bcd        in   4*DECIMAL_DIGITS  packed BCD, digit 0 in [3:0]
//   i_start      in   1                 start request
//   o_binary     out  OUTPUT_WIDTH      conversion result
//   o_dv         out  1                 one-cycle completion strobe
//   o_busy       out  1                 high while not idle
//   o_bad_digit  out  1                 invalid input digit (with o_dv)
//   o_overflow   out  1                 result truncated (with o_dv)
// ----------------------------------------------------------------------------
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [BCD_DIGIT_W*DECIMAL_DIGITS-1:0] i_bcd,
  input  logic                                i_start,
  output logic [OUTPUT_WIDTH-1:0]             o_binary,
  output logic                                o_dv,
  output logic                                o_busy,
  output logic                                o_bad_digit,
  output logic                                o_overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DECIMAL_DIGITS;
  localparam int CNT_W = $clog2(OUTPUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OUTPUT_WIDTH - 1);

`ifdef BCD2BIN_VALIDATE_EN
  localparam bit VALIDATE_EN = 1'b1;
`else
  localparam bit VALIDATE_EN = 1'b0;
`endif

  bcd_state_e              state;
  logic [BCD_W-1:0]        s_q;
  logic [OUTPUT_WIDTH-1:0] r_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [BCD_W-1:0]        s_shift;
  logic [BCD_W-1:0]        s_adj;
  logic [OUTPUT_WIDTH-1:0] r_shift;
  logic                    bad_digit;

  // One combined right shift of {S,R}: S LSB moves into R MSB.
  assign s_shift = {1'b0, s_q[BCD_W-1:1]};
  assign r_shift = {s_q[0], r_q[OUTPUT_WIDTH-1:1]};

  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (s_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (s_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (i_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      o_binary    <= '0;
      o_dv        <= 1'b0;
      o_busy      <= 1'b0;
      o_bad_digit <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      // Strobe and its qualifiers default low every cycle.
      o_dv        <= 1'b0;
      o_bad_digit <= 1'b0;
      o_overflow  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (VALIDATE_EN && bad_digit) begin
              // Reject without entering SHIFT; o_binary keeps its value.
              o_dv        <= 1'b1;
              o_bad_digit <= 1'b1;
            end else begin
              s_q    <= i_bcd;
              r_q    <= '0;
              cnt_q  <= '0;
              o_busy <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          s_q   <= s_adj;
          r_q   <= r_shift;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            // Any value left in S after the final shift did not fit in R.
            o_binary   <= r_shift;
            o_dv       <= 1'b1;
            o_overflow <= VALIDATE_EN && (s_adj != '0);
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule : bcd_to_binary
